// File: rtl/ex_div_unit_if.sv
// Bundles the EX-stage divider request, MTHI/MTLO and result signals.
interface ex_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             is_unsigned;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             kill;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] mt_wdata;
  logic             stall;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;

  // Pipeline side: issues divides and MT writes, observes results.
  modport master (
    output start, is_unsigned, dividend, divisor, kill, hi_we, lo_we, mt_wdata,
    input  stall, busy, done, div_by_zero, hi_out, lo_out
  );

  // Divider side.
  modport slave (
    input  start, is_unsigned, dividend, divisor, kill, hi_we, lo_we, mt_wdata,
    output stall, busy, done, div_by_zero, hi_out, lo_out
  );
endinterface

// File: rtl/ex_div_unit.sv
// Iterative restoring divider for DIV/DIVU, one quotient bit per cycle.
// Owns the architectural HI (remainder) and LO (quotient) registers.
module ex_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic          clk,
  input logic          rst,
  ex_div_unit_if.slave dif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvsr;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             sign_q;
  logic             sign_r;
  logic             dz;
  logic             busy_q;
  logic             done_q;
  logic             dbz_q;

  logic [WIDTH-1:0] abs_dvd;
  logic [WIDTH-1:0] abs_dvs;
  logic             dvd_neg;
  logic             dvs_neg;
  logic [WIDTH:0]   shl;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  // Operand magnitude/sign extraction, restoring trial step and sign fixup.
  always_comb begin
    dvd_neg = ~dif.is_unsigned & dif.dividend[WIDTH-1];
    dvs_neg = ~dif.is_unsigned & dif.divisor[WIDTH-1];
    abs_dvd = dvd_neg ? ('0 - dif.dividend) : dif.dividend;
    abs_dvs = dvs_neg ? ('0 - dif.divisor) : dif.divisor;
    // {rem,quo} shifted left by one; top bit kept so the trial never loses a bit
    shl     = {rem, quo[WIDTH-1]};
    trial   = shl - {1'b0, dvsr};
    quo_fix = sign_q ? ('0 - quo) : quo;
    rem_fix = sign_r ? ('0 - rem) : rem;
  end

  // Control FSM, datapath registers and HI/LO.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      rem    <= '0;
      quo    <= '0;
      dvsr   <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      dz     <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
      // MT writes only while idle; a same-edge start is later overwritten by the result
      if (state == S_IDLE) begin
        if (dif.hi_we) hi_q <= dif.mt_wdata;
        if (dif.lo_we) lo_q <= dif.mt_wdata;
      end
      if (dif.kill) begin
        state  <= S_IDLE;
        cnt    <= '0;
        busy_q <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (dif.start) begin
              rem    <= '0;
              quo    <= abs_dvd;
              dvsr   <= abs_dvs;
              sign_q <= dvd_neg ^ dvs_neg;
              sign_r <= dvd_neg;
              dz     <= (dif.divisor == '0);
              cnt    <= CNT_W'(WIDTH);
              state  <= S_BUSY;
              busy_q <= 1'b1;
            end
          end
          S_BUSY: begin
            if (!trial[WIDTH]) begin
              rem <= trial[WIDTH-1:0];
              quo <= {quo[WIDTH-2:0], 1'b1};
            end else begin
              rem <= shl[WIDTH-1:0];
              quo <= {quo[WIDTH-2:0], 1'b0};
            end
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
              state  <= S_DONE;
              done_q <= 1'b1;
              dbz_q  <= dz;
            end
          end
          S_DONE: begin
            lo_q   <= quo_fix;
            hi_q   <= rem_fix;
            state  <= S_IDLE;
            busy_q <= 1'b0;
          end
          default: begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
          end
        endcase
      end
    end
  end

  // Hazard stall: covers the issuing IDLE cycle plus the whole operation.
  always_comb begin
    dif.stall = ((state == S_IDLE) & dif.start & ~dif.kill) | (state != S_IDLE);
  end

  assign dif.busy        = busy_q;
  assign dif.done        = done_q;
  assign dif.div_by_zero = dbz_q;
  assign dif.hi_out      = hi_q;
  assign dif.lo_out      = lo_q;

endmodule

// File: tb/tb_ex_div_unit.sv
// Scoreboard bench for ex_div_unit: expected HI/LO pushed at issue,
// popped in the first cycle after stall drops.
module tb_ex_div_unit;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         dbz;
  } exp_t;

  logic clk;
  logic rst;

  ex_div_unit_if #(.WIDTH(W)) dif ();

  ex_div_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .dif (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int           n_cmp;
  int           n_err;
  int           done_cnt;
  exp_t         sb[$];
  logic         pend;
  logic         dbz_obs;
  logic [W-1:0] last_lo;
  logic [W-1:0] last_hi;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Result monitor: done seen in one cycle, HI/LO compared in the next.
  always @(negedge clk) begin
    exp_t e;
    if (pend) begin
      pend = 1'b0;
      if (sb.size() == 0) begin
        check("unexpected_result", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        check("lo_out", {32'd0, dif.lo_out}, {32'd0, e.lo});
        check("hi_out", {32'd0, dif.hi_out}, {32'd0, e.hi});
        check("div_by_zero", {63'd0, dbz_obs}, {63'd0, e.dbz});
      end
    end
    if (dif.done === 1'b1) begin
      pend     = 1'b1;
      dbz_obs  = dif.div_by_zero;
      done_cnt = done_cnt + 1;
    end
  end

  // Issue one divide, check stall length and done position; MTLO/MTHI attempts
  // during BUSY and DONE must be ignored. Optionally MTHI alongside start.
  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic uns,
                         input logic [W-1:0] exp_lo, input logic [W-1:0] exp_hi,
                         input logic exp_dbz, input logic mt_with_start);
    exp_t e;
    int   n;
    int   dcyc;
    @(posedge clk); #1;
    dif.start       = 1'b1;
    dif.is_unsigned = uns;
    dif.dividend    = a;
    dif.divisor     = b;
    dif.hi_we       = mt_with_start;
    dif.mt_wdata    = 32'h5555_0000;
    e.lo = exp_lo; e.hi = exp_hi; e.dbz = exp_dbz;
    sb.push_back(e);
    n    = 0;
    dcyc = -1;
    @(negedge clk);
    while (dif.stall === 1'b1 && n < 100) begin
      if (dif.done === 1'b1) dcyc = n;
      if (mt_with_start && n == 1) check("mthi_with_start", {32'd0, dif.hi_out}, 64'h5555_0000);
      n++;
      @(posedge clk); #1;
      dif.start    = 1'b0;
      dif.hi_we    = (n == 6);
      dif.lo_we    = (n == 5) || (n == 33);
      dif.mt_wdata = 32'hDEAD_BEEF;
      dif.dividend = $urandom;
      dif.divisor  = $urandom;
      @(negedge clk);
    end
    dif.hi_we = 1'b0;
    dif.lo_we = 1'b0;
    check("stall_cycles", 64'(n), 64'd34);
    check("done_cycle", 64'(dcyc), 64'd33);
    last_lo = exp_lo;
    last_hi = exp_hi;
    @(negedge clk);
    check("sb_drained", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    int           dc0;
    logic [W-1:0] a;
    logic [W-1:0] b;
    n_cmp = 0; n_err = 0; done_cnt = 0; pend = 1'b0; dbz_obs = 1'b0;
    last_lo = '0; last_hi = '0;
    rst = 1'b1;
    dif.start = 1'b0; dif.is_unsigned = 1'b0; dif.dividend = '0; dif.divisor = '0;
    dif.kill = 1'b0; dif.hi_we = 1'b0; dif.lo_we = 1'b0; dif.mt_wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_busy", {63'd0, dif.busy}, 64'd0);
    check("rst_stall", {63'd0, dif.stall}, 64'd0);
    check("rst_done", {63'd0, dif.done}, 64'd0);
    check("rst_dbz", {63'd0, dif.div_by_zero}, 64'd0);
    check("rst_hi", {32'd0, dif.hi_out}, 64'd0);
    check("rst_lo", {32'd0, dif.lo_out}, 64'd0);

    run_div(32'd100, 32'd7, 1'b1, 32'd14, 32'd2, 1'b0, 1'b1);
    run_div(32'hFFFF_FFF9, 32'd2, 1'b0, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_div(32'd7, 32'hFFFF_FFFE, 1'b0, 32'hFFFF_FFFD, 32'd1, 1'b0, 1'b0);
    run_div(32'hFFFF_FFFF, 32'd2, 1'b1, 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0);
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 32'd0, 1'b0, 1'b0);
    run_div(32'h1234, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'h1234, 1'b1, 1'b0);
    // signed -7/0: all-ones quotient and |dividend| remainder, both sign-fixed
    run_div(32'hFFFF_FFF9, 32'd0, 1'b0, 32'd1, 32'hFFFF_FFF9, 1'b1, 1'b0);

    // MTHI preload, then kill mid-divide
    @(posedge clk); #1;
    dif.hi_we = 1'b1; dif.mt_wdata = 32'hAAAA;
    @(posedge clk); #1;
    dif.hi_we = 1'b0;
    dif.start = 1'b1; dif.is_unsigned = 1'b1; dif.dividend = 32'd50; dif.divisor = 32'd5;
    dc0 = done_cnt;
    @(posedge clk); #1;
    dif.start = 1'b0;
    repeat (9) @(posedge clk);
    #1 dif.kill = 1'b1;
    @(posedge clk); #1;
    dif.kill = 1'b0;
    @(negedge clk);
    check("kill_busy", {63'd0, dif.busy}, 64'd0);
    check("kill_stall", {63'd0, dif.stall}, 64'd0);
    check("kill_hi", {32'd0, dif.hi_out}, 64'h0000_AAAA);
    check("kill_lo", {32'd0, dif.lo_out}, {32'd0, last_lo});
    repeat (40) @(negedge clk);
    check("kill_no_done", 64'(done_cnt), 64'(dc0));

    // start together with kill in IDLE
    @(posedge clk); #1;
    dif.start = 1'b1; dif.kill = 1'b1;
    @(negedge clk);
    check("startkill_stall", {63'd0, dif.stall}, 64'd0);
    @(posedge clk); #1;
    dif.start = 1'b0; dif.kill = 1'b0;
    @(negedge clk);
    check("startkill_busy", {63'd0, dif.busy}, 64'd0);

    // reset mid-divide
    @(posedge clk); #1;
    dif.start = 1'b1; dif.is_unsigned = 1'b1; dif.dividend = 32'd1000; dif.divisor = 32'd3;
    dc0 = done_cnt;
    @(posedge clk); #1;
    dif.start = 1'b0;
    repeat (19) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rstmid_busy", {63'd0, dif.busy}, 64'd0);
    check("rstmid_stall", {63'd0, dif.stall}, 64'd0);
    check("rstmid_hi", {32'd0, dif.hi_out}, 64'd0);
    check("rstmid_lo", {32'd0, dif.lo_out}, 64'd0);
    repeat (40) @(negedge clk);
    check("rstmid_no_done", 64'(done_cnt), 64'(dc0));

    // random operands against a behavioural model
    for (int i = 0; i < 4; i++) begin
      a = $urandom;
      b = 32'($urandom_range(1, 100000));
      run_div(a, b, 1'b1, a / b, a % b, 1'b0, 1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      a = $urandom;
      b = $urandom;
      if (b == '0 || (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) b = 32'd3;
      if (i[0]) b = 32'($signed(b) >>> 20);
      if (b == '0) b = 32'hFFFF_FFF5;
      run_div(a, b, 1'b0, 32'($signed(a) / $signed(b)), 32'($signed(a) % $signed(b)), 1'b0, 1'b0);
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ex_div_unit.md
Name: ex_div_unit

Overview:
- Iterative multi-cycle divider in the EX stage, fed from the ID/EX register.
- Fed when the decoder classifies an RTYPE instruction as DIV or DIVU. For these, the decoder suppresses regWrite, so no GPR writeback occurs.
- Computes quotient and remainder into the architectural LO and HI registers.
- Raises a stall to the hazard unit for the whole operation, so a following MFHI/MFLO always reads the new result.

Parameters:
- WIDTH, 32, operand/result width in bits.
- CNT_W, 6, iteration counter width; must hold the value WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  EX holds a DIV/DIVU; sampled only in IDLE.
- is_unsigned  input  1  1 = DIVU, 0 = DIV (signed); sampled with start.
- dividend  input  WIDTH  rs operand; sampled with start.
- divisor  input  WIDTH  rt operand; sampled with start.
- kill  input  1  abort request from flush/exception logic.
- hi_we  input  1  MTHI write enable.
- lo_we  input  1  MTLO write enable.
- mt_wdata  input  WIDTH  MTHI/MTLO write data.
- stall  output  1  freeze IF/ID/EX; combinational.
- busy  output  1  state != IDLE; registered.
- done  output  1  one-cycle completion pulse; registered state decode.
- div_by_zero  output  1  valid while done=1; divisor was 0.
- hi_out  output  WIDTH  HI register (remainder).
- lo_out  output  WIDTH  LO register (quotient).

Behaviour:
- Reset: state=IDLE; counter=0; HI=0; LO=0; stall=0; busy=0; done=0; div_by_zero=0. Reset in any state aborts any operation; HI/LO are cleared.
- States: IDLE, BUSY, DONE.
- IDLE with start=1 and kill=0, at the clock edge:
  - Latch |dividend| and |divisor|. Absolute values apply only when is_unsigned=0 and the operand MSB is 1.
  - Latch sign_q = sign(dividend) XOR sign(divisor), and sign_r = sign(dividend). Both signs are forced to 0 for unsigned.
  - Latch the divisor-zero flag and set counter=WIDTH.
  - Go to BUSY.
- BUSY: one restoring step per cycle.
  - Shift {rem,quo} left by 1 and trial-subtract the divisor from rem.
  - If no borrow, keep the difference and set the quotient LSB to 1; otherwise restore and set it to 0.
  - Decrement the counter. On the edge where the counter goes 1->0, go to DONE.
- DONE (exactly one cycle):
  - done=1.
  - Sign fixup: quotient negated if sign_q; remainder negated if sign_r.
  - At the edge leaving DONE, LO<=quotient and HI<=remainder; then go to IDLE.
- stall = (IDLE & start & ~kill) | BUSY | DONE.
  - Total stall = WIDTH+2 cycles (34 for WIDTH=32).
  - HI/LO are valid in the first cycle after stall drops.
- Divide by zero:
  - Full latency is still taken.
  - Result is quotient = all ones (unsigned: 0xFFFFFFFF; signed: before fixup), remainder = dividend (signed: before fixup).
  - div_by_zero=1 during DONE.
- Signed overflow, 0x80000000 / -1: quotient = 0x80000000, remainder = 0. This is natural two's-complement wrap with no special case.
- kill: from any state, go to IDLE at the next edge.
  - HI/LO are not written and done does not pulse.
  - kill has priority over start in the same cycle, and stall is 0 while kill=1 in IDLE.
- start while BUSY/DONE: ignored, since it cannot legally occur because stall holds EX.
- MTHI/MTLO: honoured only in IDLE; ignored in BUSY/DONE.
  - In IDLE, a simultaneous start and hi_we/lo_we both take effect. The MT write lands this edge, and the later divide result overwrites it.
- Operands are held internally, so upstream may change dividend/divisor after the start edge.

Test Plan:
- Unsigned 100/7: start with is_unsigned=1 -> stall high 34 cycles, done at cycle 33; then lo_out=14, hi_out=2.
- Signed -7/2 (0xFFFFFFF9 / 0x00000002) -> lo_out=0xFFFFFFFD (-3), hi_out=0xFFFFFFFF (-1). Also check 7/-2 -> lo=0xFFFFFFFD, hi=1.
- Unsigned 0xFFFFFFFF/2 -> lo=0x7FFFFFFF, hi=1. Signed 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- Divide by zero, unsigned 0x1234/0 -> div_by_zero=1 in the done cycle; lo=0xFFFFFFFF, hi=0x1234.
- Preload HI=0xAAAA via MTHI, start 50/5, assert kill at BUSY cycle 10 -> next cycle state IDLE, stall=0, done never pulses; hi_out stays 0xAAAA and lo_out is unchanged. A start concurrent with kill in IDLE -> no stall.
- Assert rst at BUSY cycle 20 -> next cycle busy=0, stall=0, hi_out=lo_out=0. MTLO attempted during BUSY of a separate divide -> LO gets only the divide result.
